// File: rtl/xor_parity_rx.sv
// rtl/xor_parity_rx.sv - LSB-first serial parity receiver with valid/ready word output (optional ERR_CNT under XOR_PARITY_RX_ERRCNT_EN)
module xor_parity_rx #(
    parameter int   DATA_W     = 8,
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              SYNC_CLR,
    input  logic              DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic [DATA_W-1:0] DOUT,
    output logic              PAR_ERR,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [7:0]        ERR_CNT
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_count;
    logic                r_acc;
    logic [DATA_W-1:0]   r_dout;
    logic                r_par_err;
    logic                r_dout_valid;

    logic                w_accept;
    logic                w_last_data;
    logic                w_par_err;

    // The input side stalls only while a finished word waits for the consumer.
    assign DIN_READY   = !r_dout_valid;
    assign w_accept    = DIN_VALID && DIN_READY;
    assign w_last_data = (r_count == CNT_W'(DATA_W - 1));
    assign w_par_err   = r_acc ^ DIN ^ PARITY_ODD;

    assign DOUT       = r_dout;
    assign PAR_ERR    = r_par_err;
    assign DOUT_VALID = r_dout_valid;

    // Frame state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: abort wins over acceptance and over the output handshake.
    always_comb begin
        w_state_next = r_state;
        if (SYNC_CLR) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_accept) w_state_next = S_DATA;
                S_DATA:   if (w_accept && w_last_data) w_state_next = S_PARITY;
                S_PARITY: if (w_accept) w_state_next = S_HOLD;
                S_HOLD:   if (r_dout_valid && DOUT_READY) w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Shift, running XOR and output word; DOUT/PAR_ERR survive an abort.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_acc        <= 1'b0;
            r_dout       <= '0;
            r_par_err    <= 1'b0;
            r_dout_valid <= 1'b0;
        end else if (SYNC_CLR) begin
            r_shift      <= '0;
            r_count      <= '0;
            r_acc        <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift[0] <= DIN;
                        r_acc      <= DIN;
                        r_count    <= CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_shift[r_count] <= DIN;
                        r_acc            <= r_acc ^ DIN;
                        if (!w_last_data) begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_accept) begin
                        r_dout       <= r_shift;
                        r_par_err    <= w_par_err;
                        r_dout_valid <= 1'b1;
                        r_count      <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_dout_valid && DOUT_READY) begin
                        r_dout_valid <= 1'b0;
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef XOR_PARITY_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of bad-parity frames; a clear beats an increment.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err_cnt <= 8'h00;
        end else if (SYNC_CLR) begin
            r_err_cnt <= 8'h00;
        end else if ((r_state == S_PARITY) && w_accept && w_par_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`else
    assign ERR_CNT = 8'h00;
`endif

endmodule
